seg_scan_reader: RTL and testbench

SEG_SCAN_READER -- requirements
Module: seg_scan_reader

---
 rtl/seg_pkg.sv | 21 ++
 rtl/seg_pattern_decode.sv | 22 ++
 rtl/seg_scan_reader.sv | 128 ++++++++++++
 tb/tb_seg_scan_reader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scan reader:
// segment decode table, error flag polarity, FSM encodings and defaults.
package seg_pkg;

  localparam int STABLE_CNT_DEFAULT = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_HELD  = 2'd2;

  localparam logic SEG_INVALID = 1'b1;

  // Index = hex value, entry = ABCDEFG pattern (A is the MSB)
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational seven-segment pattern to hex decoder; unknown patterns
// decode to zero with the error flag raised.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       err
);

  always_comb begin
    value = 4'h0;
    err   = SEG_INVALID;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_TABLE[i]) begin
        value = 4'(i);
        err   = ~SEG_INVALID;
      end
    end
  end

endmodule

// File: rtl/seg_scan_reader.sv
// Samples a multiplexed seven-segment display, debounces each digit and
// publishes a complete four-digit frame once every digit has been captured.
module seg_scan_reader
  import seg_pkg::*;
#(
  parameter int STABLE_CNT = STABLE_CNT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  dig_en,
  output logic [15:0] digits,
  output logic [3:0]  err,
  output logic        frame_strobe,
  output logic        frame_valid
);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [6:0]  prev_seg;
  logic [3:0]  prev_dig;
  logic [15:0] stage_digits;
  logic [3:0]  stage_err;
  logic [3:0]  mask;
  logic [3:0]  next_mask;
  logic [1:0]  dig_idx;
  logic [3:0]  dec_value;
  logic        dec_err;
  logic        onehot;
  logic        same;
  logic        capture;

  seg_pattern_decode u_decode (
    .pattern (seg),
    .value   (dec_value),
    .err     (dec_err)
  );

  assign onehot  = $onehot(dig_en);
  assign same    = (seg == prev_seg) && (dig_en == prev_dig);
  assign capture = onehot && (state == ST_TRACK) && same &&
                   (cnt == 4'(STABLE_CNT - 1));

  always_comb begin
    dig_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (dig_en[i]) dig_idx = 2'(i);
    end
  end

  // A full mask is consumed by the frame copy, so a simultaneous capture
  // starts the next frame on its own.
  always_comb begin
    next_mask = (mask == 4'hF) ? 4'h0 : mask;
    if (capture) next_mask = next_mask | (4'b0001 << dig_idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_seg <= 7'd0;
      prev_dig <= 4'd0;
    end else begin
      prev_seg <= seg;
      prev_dig <= dig_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else if (!onehot) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_TRACK;
          cnt   <= 4'd1;
        end
        ST_TRACK: begin
          if (same) begin
            cnt <= cnt + 4'd1;
            if (capture) state <= ST_HELD;
          end else begin
            cnt <= 4'd1;
          end
        end
        ST_HELD: begin
          if (!same) begin
            state <= ST_TRACK;
            cnt   <= 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_digits <= 16'h0000;
      stage_err    <= 4'b0000;
      mask         <= 4'b0000;
      digits       <= 16'h0000;
      err          <= 4'b0000;
      frame_strobe <= 1'b0;
      frame_valid  <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      if (mask == 4'hF) begin
        digits       <= stage_digits;
        err          <= stage_err;
        frame_strobe <= 1'b1;
        frame_valid  <= 1'b1;
      end
      if (capture) begin
        stage_digits[{dig_idx, 2'b00} +: 4] <= dec_value;
        stage_err[dig_idx]                  <= dec_err;
      end
      mask <= next_mask;
    end
  end

endmodule

// File: tb/tb_seg_scan_reader.sv
// Self-checking bench for seg_scan_reader: directed scenarios plus random
// scan traffic compared every cycle against a run-length reference model.
module tb_seg_scan_reader;

  localparam int STABLE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic [15:0] digits;
  logic [3:0]  err;
  logic        frame_strobe;
  logic        frame_valid;

  int checks = 0;
  int failures = 0;
  int dut_strobes = 0;

  logic [6:0] ref_table [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Reference model: run length of identical one-hot samples, staged values,
  // set of digits captured in the current frame, and the published frame.
  logic [6:0]  m_prev_seg;
  logic [3:0]  m_prev_dig;
  int          m_run;
  logic [15:0] m_stage_d;
  logic [3:0]  m_stage_e;
  logic [3:0]  m_mask;
  logic [15:0] m_digits;
  logic [3:0]  m_err;
  logic        m_strobe;
  logic        m_valid;

  seg_scan_reader #(.STABLE_CNT(STABLE)) dut (
    .clk          (clk),
    .rst          (rst),
    .seg          (seg),
    .dig_en       (dig_en),
    .digits       (digits),
    .err          (err),
    .frame_strobe (frame_strobe),
    .frame_valid  (frame_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic void refDecode(input logic [6:0] p, output logic [3:0] v,
                                    output logic e);
    v = 4'h0;
    e = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (p == ref_table[i]) begin
        v = i[3:0];
        e = 1'b0;
      end
    end
  endfunction

  task automatic modelReset();
    m_prev_seg = 7'd0;
    m_prev_dig = 4'd0;
    m_run      = 0;
    m_stage_d  = 16'h0;
    m_stage_e  = 4'h0;
    m_mask     = 4'h0;
    m_digits   = 16'h0;
    m_err      = 4'h0;
    m_strobe   = 1'b0;
    m_valid    = 1'b0;
  endtask

  task automatic modelStep(input logic [3:0] dig, input logic [6:0] s);
    logic [3:0] v;
    logic       e;
    int         idx;
    if (m_mask == 4'hF) begin
      m_digits = m_stage_d;
      m_err    = m_stage_e;
      m_strobe = 1'b1;
      m_valid  = 1'b1;
      m_mask   = 4'h0;
    end else begin
      m_strobe = 1'b0;
    end
    if ($onehot(dig)) begin
      if (dig == m_prev_dig && s == m_prev_seg) m_run = (m_run < 1000) ? m_run + 1 : m_run;
      else m_run = 1;
    end else begin
      m_run = 0;
    end
    if (m_run == STABLE) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (dig[i]) idx = i;
      refDecode(s, v, e);
      m_stage_d[idx*4 +: 4] = v;
      m_stage_e[idx] = e;
      m_mask[idx] = 1'b1;
    end
    m_prev_dig = dig;
    m_prev_seg = s;
  endtask

  task automatic applyStimulus(input logic [3:0] dig, input logic [6:0] s, input int n);
    for (int k = 0; k < n; k++) begin
      dig_en = dig;
      seg    = s;
      @(posedge clk);
      #1;
      modelStep(dig, s);
      if (frame_strobe) dut_strobes++;
      checkOutput("digits", digits, m_digits);
      checkOutput("err", {12'h0, err}, {12'h0, m_err});
      checkOutput("frame_strobe", {15'h0, frame_strobe}, {15'h0, m_strobe});
      checkOutput("frame_valid", {15'h0, frame_valid}, {15'h0, m_valid});
      @(negedge clk);
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst    = 1'b1;
    dig_en = 4'b0000;
    seg    = 7'd0;
    #1;
    checkOutput("rst_digits", digits, 16'h0000);
    checkOutput("rst_err", {12'h0, err}, 16'h0000);
    checkOutput("rst_strobe", {15'h0, frame_strobe}, 16'h0000);
    checkOutput("rst_valid", {15'h0, frame_valid}, 16'h0000);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int s0;
    logic [3:0] d;
    logic [6:0] p;
    rst    = 1'b1;
    dig_en = 4'b0000;
    seg    = 7'd0;
    modelReset();
    #12;
    checkOutput("init_digits", digits, 16'h0000);
    checkOutput("init_valid", {15'h0, frame_valid}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Basic frame 0,1,2,3
    s0 = dut_strobes;
    applyStimulus(4'b0001, 7'b1111110, 3);
    applyStimulus(4'b0010, 7'b0110000, 3);
    applyStimulus(4'b0100, 7'b1101101, 3);
    applyStimulus(4'b1000, 7'b1111001, 3);
    applyStimulus(4'b0000, 7'b0000000, 1);
    checkOutput("basic_digits", digits, 16'h3210);
    checkOutput("basic_err", {12'h0, err}, 16'h0000);
    checkOutput("basic_strobes", 16'(dut_strobes - s0), 16'd1);

    // Too-short dwell on digit 0 never captures it
    s0 = dut_strobes;
    applyStimulus(4'b0001, 7'b1111110, 2);
    applyStimulus(4'b0010, 7'b0110000, 3);
    applyStimulus(4'b0100, 7'b1101101, 3);
    applyStimulus(4'b1000, 7'b1111001, 3);
    applyStimulus(4'b0000, 7'b0000000, 2);
    checkOutput("short_strobes", 16'(dut_strobes - s0), 16'd0);

    // Invalid pattern on digit 2
    applyReset();
    applyStimulus(4'b0001, 7'b1011011, 3);
    applyStimulus(4'b0010, 7'b1110111, 3);
    applyStimulus(4'b0100, 7'b0000001, 3);
    applyStimulus(4'b1000, 7'b1000111, 3);
    applyStimulus(4'b0000, 7'b0000000, 1);
    checkOutput("inval_err", {12'h0, err}, 16'h0004);
    checkOutput("inval_digits", digits, 16'hF0A5);

    // Non-one-hot glitch restarts the stability count
    applyReset();
    s0 = dut_strobes;
    applyStimulus(4'b0001, 7'b1111111, 2);
    applyStimulus(4'b0011, 7'b1111111, 1);
    applyStimulus(4'b0001, 7'b1111111, 2);
    applyStimulus(4'b0010, 7'b0110000, 3);
    applyStimulus(4'b0100, 7'b1101101, 3);
    applyStimulus(4'b1000, 7'b1111001, 3);
    applyStimulus(4'b0000, 7'b0000000, 1);
    checkOutput("glitch_nostrobe", 16'(dut_strobes - s0), 16'd0);
    applyStimulus(4'b0001, 7'b1111111, 3);
    applyStimulus(4'b0000, 7'b0000000, 1);
    checkOutput("glitch_strobe", 16'(dut_strobes - s0), 16'd1);
    checkOutput("glitch_digits", digits, 16'h3218);

    // Reset in the middle of a partial frame
    applyReset();
    applyStimulus(4'b0001, 7'b1110000, 3);
    applyStimulus(4'b0010, 7'b1111011, 3);
    applyReset();
    s0 = dut_strobes;
    applyStimulus(4'b0001, 7'b0110000, 3);
    applyStimulus(4'b0010, 7'b1101101, 3);
    applyStimulus(4'b0100, 7'b1111001, 3);
    checkOutput("midrst_valid_low", {15'h0, frame_valid}, 16'h0000);
    applyStimulus(4'b1000, 7'b0110011, 3);
    applyStimulus(4'b0000, 7'b0000000, 2);
    checkOutput("midrst_strobes", 16'(dut_strobes - s0), 16'd1);
    checkOutput("midrst_digits", digits, 16'h4321);

    // Long dwell captures once
    applyReset();
    s0 = dut_strobes;
    applyStimulus(4'b0001, 7'b1011111, 10);
    applyStimulus(4'b0010, 7'b0110000, 3);
    applyStimulus(4'b0100, 7'b0110000, 3);
    applyStimulus(4'b1000, 7'b0110000, 3);
    applyStimulus(4'b0000, 7'b0000000, 3);
    checkOutput("long_strobes", 16'(dut_strobes - s0), 16'd1);
    checkOutput("long_digits", digits, 16'h1116);

    // Random scan traffic
    applyReset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 8) d = 4'b0001 << $urandom_range(0, 3);
      else d = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) != 0) p = ref_table[$urandom_range(0, 15)];
      else p = 7'($urandom);
      applyStimulus(d, p, $urandom_range(1, 5));
      if ($urandom_range(0, 99) == 0) applyReset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
